// File: rtl/pwm_fade_ctrl.sv
// Multi-channel LED PWM with per-channel duty fading toward a programmed target.
// Duty only changes at PWM period boundaries, so every period is glitch-free.
module pwm_fade_ctrl #(
  parameter int N_CH     = 4,
  parameter int PWM_BITS = 8,
  parameter int PRESC_W  = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [PRESC_W-1:0]  presc_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [3:0]          cfg_ch_i,
  input  logic [PWM_BITS-1:0] cfg_target_i,
  input  logic [PWM_BITS-1:0] cfg_step_i,
  output logic [N_CH-1:0]     led_o,
  output logic [N_CH-1:0]     busy_o,
  output logic [N_CH-1:0]     done_o,
  output logic                period_o
);

  typedef logic [PWM_BITS-1:0] duty_t;
  typedef enum logic [1:0] {IDLE, UP, DOWN} fade_t;

  function automatic duty_t ramp_up(input duty_t d, input duty_t s, input duty_t t);
    logic [PWM_BITS:0] sum;
    sum = {1'b0, d} + {1'b0, s};
    return (sum > {1'b0, t}) ? t : sum[PWM_BITS-1:0];
  endfunction

  function automatic duty_t ramp_down(input duty_t d, input duty_t s, input duty_t t);
    logic signed [PWM_BITS+1:0] diff;
    diff = $signed({2'b00, d}) - $signed({2'b00, s});
    return (diff < $signed({2'b00, t})) ? t : diff[PWM_BITS-1:0];
  endfunction

  logic [PRESC_W-1:0]  presc_cnt;
  logic [PRESC_W-1:0]  presc_eff;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;
  logic                period_end;
  logic                cfg_xfer;

  duty_t duty     [N_CH];
  duty_t target   [N_CH];
  duty_t step     [N_CH];
  duty_t duty_nxt [N_CH];
  fade_t dir      [N_CH];
  logic [N_CH-1:0] reach;

  logic [N_CH-1:0] led_p1;
  logic [N_CH-1:0] busy_p1;
  logic [N_CH-1:0] done_p1;
  logic            period_p1;
  logic            cfg_ready_p1;

  // presc_i is compared live, so lowering it below the running count ticks at once
  assign presc_eff  = (presc_i == '0) ? PRESC_W'(1) : presc_i;
  assign tick       = (presc_cnt >= presc_eff - PRESC_W'(1));
  assign period_end = tick && (pwm_cnt == '1);
  assign cfg_xfer   = cfg_valid_i && cfg_ready_p1;

  // Stage p0: fade direction and next duty, consumed only on period_end
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      dir[c]      = IDLE;
      duty_nxt[c] = duty[c];
      reach[c]    = 1'b0;
      if (duty[c] < target[c]) begin
        dir[c] = UP;
      end else if (duty[c] > target[c]) begin
        dir[c] = DOWN;
      end
      case (dir[c])
        UP:      duty_nxt[c] = (step[c] == '0) ? target[c] : ramp_up(duty[c], step[c], target[c]);
        DOWN:    duty_nxt[c] = (step[c] == '0) ? target[c] : ramp_down(duty[c], step[c], target[c]);
        default: duty_nxt[c] = duty[c];
      endcase
      reach[c] = (dir[c] != IDLE) && (duty_nxt[c] == target[c]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      presc_cnt    <= '0;
      pwm_cnt      <= '0;
      period_p1    <= 1'b0;
      cfg_ready_p1 <= 1'b0;
    end else begin
      presc_cnt    <= tick ? '0 : presc_cnt + PRESC_W'(1);
      pwm_cnt      <= tick ? pwm_cnt + PWM_BITS'(1) : pwm_cnt;
      period_p1    <= period_end;
      cfg_ready_p1 <= !cfg_xfer;
    end
  end

  // Stage p1: registered outputs and per-channel duty/target/step state
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      led_p1  <= '0;
      busy_p1 <= '0;
      done_p1 <= '0;
      for (int c = 0; c < N_CH; c++) begin
        duty[c]   <= '0;
        target[c] <= '0;
        step[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        led_p1[c]  <= (pwm_cnt < duty[c]);
        busy_p1[c] <= (duty[c] != target[c]);
        done_p1[c] <= period_end && reach[c];
        if (period_end) begin
          duty[c] <= duty_nxt[c];
        end
        // a write colliding with period_end lands after this period's update
        if (cfg_xfer && (int'(cfg_ch_i) == c)) begin
          target[c] <= cfg_target_i;
          step[c]   <= cfg_step_i;
        end
      end
    end
  end

  assign led_o       = led_p1;
  assign busy_o      = busy_p1;
  assign done_o      = done_p1;
  assign period_o    = period_p1;
  assign cfg_ready_o = cfg_ready_p1;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Bench for pwm_fade_ctrl: directed scenarios plus random config traffic,
// all outputs compared every cycle against an integer reference model.
module tb_pwm_fade_ctrl;
  localparam int N_CH     = 4;
  localparam int PWM_BITS = 8;
  localparam int PRESC_W  = 16;
  localparam int PMAX     = (1 << PWM_BITS) - 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [PRESC_W-1:0]  presc = 16'd1;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic [3:0]          cfg_ch = 4'd0;
  logic [PWM_BITS-1:0] cfg_target = '0;
  logic [PWM_BITS-1:0] cfg_step = '0;
  logic [N_CH-1:0]     led;
  logic [N_CH-1:0]     busy;
  logic [N_CH-1:0]     done;
  logic                period;

  always #5 clk = ~clk;

  pwm_fade_ctrl #(.N_CH(N_CH), .PWM_BITS(PWM_BITS), .PRESC_W(PRESC_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .presc_i(presc),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_ch_i(cfg_ch),
    .cfg_target_i(cfg_target), .cfg_step_i(cfg_step),
    .led_o(led), .busy_o(busy), .done_o(done), .period_o(period)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model state (plain integers)
  int m_pc, m_pwm, m_ready;
  int m_duty [N_CH];
  int m_tgt  [N_CH];
  int m_step [N_CH];
  logic [N_CH-1:0] e_led, e_busy, e_done;
  logic e_period;
  int done_seen [N_CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    miscompares++;
    $error("FAIL %s: wait bound expired", tag);
  endtask

  function automatic void model_clear();
    m_pc = 0; m_pwm = 0; m_ready = 0;
    e_led = '0; e_busy = '0; e_done = '0; e_period = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      m_duty[c] = 0; m_tgt[c] = 0; m_step[c] = 0;
    end
  endfunction

  function automatic void model_edge();
    int p, nd, ch;
    bit tick, pend, xfer;
    p    = (presc == 0) ? 1 : int'(presc);
    tick = (m_pc >= p - 1);
    pend = tick && (m_pwm == PMAX);
    e_period = pend;
    for (int c = 0; c < N_CH; c++) begin
      e_led[c]  = (m_pwm < m_duty[c]);
      e_busy[c] = (m_duty[c] != m_tgt[c]);
      e_done[c] = 1'b0;
      if (pend) begin
        nd = m_duty[c];
        if (m_duty[c] != m_tgt[c] && m_step[c] == 0) nd = m_tgt[c];
        else if (m_duty[c] < m_tgt[c]) nd = (m_duty[c] + m_step[c] > m_tgt[c]) ? m_tgt[c] : m_duty[c] + m_step[c];
        else if (m_duty[c] > m_tgt[c]) nd = (m_duty[c] - m_step[c] < m_tgt[c]) ? m_tgt[c] : m_duty[c] - m_step[c];
        e_done[c] = (m_duty[c] != m_tgt[c]) && (nd == m_tgt[c]);
        m_duty[c] = nd;
      end
    end
    xfer = cfg_valid && (m_ready != 0);
    ch = int'(cfg_ch);
    if (xfer && ch < N_CH) begin
      m_tgt[ch]  = int'(cfg_target);
      m_step[ch] = int'(cfg_step);
    end
    m_ready = xfer ? 0 : 1;
    m_pc  = tick ? 0 : m_pc + 1;
    m_pwm = tick ? (m_pwm + 1) % (PMAX + 1) : m_pwm;
  endfunction

  task automatic check_outputs();
    chk("cfg_ready", {31'd0, cfg_ready}, m_ready);
    chk("led", {28'd0, led}, {28'd0, e_led});
    chk("busy", {28'd0, busy}, {28'd0, e_busy});
    chk("done", {28'd0, done}, {28'd0, e_done});
    chk("period", {31'd0, period}, {31'd0, e_period});
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_outputs();
    for (int c = 0; c < N_CH; c++) if (done[c]) done_seen[c]++;
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    #1;
    model_clear();
    check_outputs();
    repeat (n) cycle();
    rst_n = 1'b1;
  endtask

  task automatic send_cfg(input int ch, input int t, input int s);
    int g = 0;
    while (m_ready == 0 && g < 4) begin cycle(); g++; end
    cfg_ch = 4'(ch); cfg_target = 8'(t); cfg_step = 8'(s); cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_pulse();
    int n = 0;
    do begin cycle(); n++; end while (!period && n < 5000);
    chk("period_seen", {31'd0, period}, 1);
  endtask

  task automatic count_period(input int ch, output int cycles, output int highs);
    cycles = 0; highs = 0;
    do begin
      cycle(); cycles++;
      if (led[ch]) highs++;
    end while (!period && cycles < 5000);
  endtask

  initial begin
    int ncyc, highs, d0, d2, g;
    int up_seq [4];
    int dn_seq [3];
    up_seq = '{3, 6, 9, 10};
    dn_seq = '{6, 2, 0};
    for (int c = 0; c < N_CH; c++) done_seen[c] = 0;

    // reset and idle
    #2;
    apply_reset(3);
    cycle();
    chk("ready_after_release", {31'd0, cfg_ready}, 1);
    wait_pulse();
    count_period(0, ncyc, highs);
    chk("idle_gap", ncyc, 256);
    chk("idle_led0", highs, 0);

    // jump to 64
    d0 = done_seen[0];
    send_cfg(0, 64, 0);
    wait_pulse();
    count_period(0, ncyc, highs);
    chk("jump_duty", highs, 64);
    chk("jump_done", done_seen[0] - d0, 1);
    chk("jump_busy", {31'd0, busy[0]}, 0);

    // ramp up by 3 to 10, then down by 4 to 0
    d0 = done_seen[1];
    send_cfg(1, 10, 3);
    wait_pulse();
    for (int i = 0; i < 4; i++) begin
      count_period(1, ncyc, highs);
      chk("ramp_up_duty", highs, up_seq[i]);
      chk("ramp_up_done", done_seen[1] - d0, (i >= 2) ? 1 : 0);
    end
    d0 = done_seen[1];
    send_cfg(1, 0, 4);
    wait_pulse();
    for (int i = 0; i < 3; i++) begin
      count_period(1, ncyc, highs);
      chk("ramp_dn_duty", highs, dn_seq[i]);
      chk("ramp_dn_done", done_seen[1] - d0, (i >= 1) ? 1 : 0);
    end

    // prescaler rates
    presc = 16'd4;
    wait_pulse();
    count_period(0, ncyc, highs);
    chk("presc4_gap", ncyc, 1024);
    chk("presc4_duty", highs, 256);
    presc = 16'd0;
    wait_pulse();
    count_period(0, ncyc, highs);
    chk("presc0_gap", ncyc, 256);

    // live lowering of presc_i: park at pwm=255, then 100 -> 2 at count 50
    presc = 16'd1;
    g = 0;
    while (m_pwm != PMAX && g < 2000) begin cycle(); g++; end
    if (g >= 2000) timeout("park_pwm");
    presc = 16'd100;
    g = 0;
    while (m_pc != 50 && g < 200) begin cycle(); g++; end
    if (g >= 200) timeout("presc_cnt_50");
    presc = 16'd2;
    cycle();
    chk("presc_live_tick", {31'd0, period}, 1);
    presc = 16'd1;

    // config on the exact period_end cycle, with a back-to-back request
    g = 0;
    while (!(m_pwm == PMAX && m_ready != 0) && g < 2000) begin cycle(); g++; end
    if (g >= 2000) timeout("collision_align");
    d0 = done_seen[0];
    d2 = done_seen[2];
    cfg_ch = 4'd2; cfg_target = 8'd200; cfg_step = 8'd0; cfg_valid = 1'b1;
    cycle();
    chk("coll_period", {31'd0, period}, 1);
    chk("coll_ready_drop", {31'd0, cfg_ready}, 0);
    cfg_ch = 4'd0; cfg_target = 8'd64; cfg_step = 8'd0;
    cycle();
    chk("b2b_ready_back", {31'd0, cfg_ready}, 1);
    cycle();
    cfg_valid = 1'b0;
    count_period(2, ncyc, highs);
    chk("coll_old_duty", highs, 0);
    count_period(2, ncyc, highs);
    chk("coll_new_duty", highs, 200);
    chk("coll_done2", done_seen[2] - d2, 1);
    chk("same_target_no_done", done_seen[0] - d0, 0);

    // reset in the middle of a slow fade
    send_cfg(3, 255, 1);
    g = 0;
    while (m_duty[3] != 40 && g < 20000) begin cycle(); g++; end
    if (g >= 20000) timeout("fade_to_40");
    d0 = done_seen[3];
    apply_reset(4);
    repeat (300) cycle();
    chk("reset_no_done", done_seen[3] - d0, 0);
    chk("reset_idle_busy", {28'd0, busy}, 0);

    // random configuration traffic
    for (int i = 0; i < 3000; i++) begin
      cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_ch     = 4'($urandom_range(0, 7));
      cfg_target = 8'($urandom_range(0, 255));
      cfg_step   = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) presc = 16'($urandom_range(0, 2));
      cycle();
    end
    cfg_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
